// File: rtl/loop_seq_ctrl_pkg.sv
// loop_seq_ctrl_pkg: shared state encoding, write-source selects and step immediates
package loop_seq_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_I,
    S_INIT_SUM,
    S_LOAD_STEP,
    S_ACC,
    S_INC,
    S_CHK,
    S_OUT,
    S_DONE
  } state_e;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_IMM = 1'b1;
  localparam int STEP_ONE = 1;
  localparam int STEP_TWO = 2;
endpackage

// File: rtl/loop_seq_ctrl_iter_watchdog.sv
// loop_seq_ctrl_iter_watchdog: saturating pass counter with clear, increment and at_limit flag
module loop_seq_ctrl_iter_watchdog #(
  parameter int MAX_ITER = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  localparam int CW = $clog2(MAX_ITER + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign at_limit = cnt_q == CW'(MAX_ITER);
  always_comb cnt_d = clr ? '0 : (inc && !at_limit) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: Moore FSM sequencing a register-file accumulate loop with watchdog and abort
module loop_seq_ctrl
  import loop_seq_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int REG_I    = 1,
  parameter int REG_SUM  = 2,
  parameter int REG_STEP = 3,
  parameter int MAX_ITER = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              iLe,
  output logic              rfsrcmuxsel,
  output logic [DATA_W-1:0] imm,
  output logic              rfwe,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  output logic              outLoad,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam logic [ADDR_W-1:0] A_I = ADDR_W'(REG_I);
  localparam logic [ADDR_W-1:0] A_SUM = ADDR_W'(REG_SUM);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(REG_STEP);
  state_e state_q, state_d;
  logic mode_q, mode_d, timeout_q, timeout_d;
  logic wd_clr, wd_inc, at_limit;
  loop_seq_ctrl_iter_watchdog #(.MAX_ITER(MAX_ITER)) u_iter_watchdog (
    .clk(clk), .reset(reset), .clr(wd_clr), .inc(wd_inc), .at_limit(at_limit)
  );
  assign busy = state_q != S_IDLE;
  assign timeout = timeout_q;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    timeout_d = timeout_q;
    wd_clr = 1'b0;
    wd_inc = 1'b0;
    rfsrcmuxsel = SRC_ALU;
    imm = '0;
    rfwe = 1'b0;
    waddr = '0;
    raddr1 = '0;
    raddr2 = '0;
    outLoad = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_INIT_I;
        mode_d = mode;
        timeout_d = 1'b0;
        wd_clr = 1'b1;
      end
      S_INIT_I: begin
        rfwe = 1'b1;
        waddr = A_I;
        state_d = S_INIT_SUM;
      end
      S_INIT_SUM: begin
        rfwe = 1'b1;
        waddr = A_SUM;
        state_d = S_LOAD_STEP;
      end
      S_LOAD_STEP: begin
        rfsrcmuxsel = SRC_IMM;
        imm = mode_q ? DATA_W'(STEP_TWO) : DATA_W'(STEP_ONE);
        rfwe = 1'b1;
        waddr = A_STEP;
        state_d = S_ACC;
      end
      S_ACC: begin
        rfwe = 1'b1;
        raddr1 = A_SUM;
        raddr2 = A_I;
        waddr = A_SUM;
        wd_inc = 1'b1;
        state_d = S_INC;
      end
      S_INC: begin
        rfwe = 1'b1;
        raddr1 = A_I;
        raddr2 = A_STEP;
        waddr = A_I;
        state_d = S_CHK;
      end
      S_CHK: begin
        raddr1 = A_I;
        state_d = (!iLe || at_limit) ? S_DONE : S_OUT;
        timeout_d = iLe && at_limit;
      end
      S_OUT: begin
        raddr1 = A_SUM;
        outLoad = 1'b1;
        state_d = S_ACC;
      end
      S_DONE: begin
        raddr1 = A_SUM;
        outLoad = 1'b1;
        done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      timeout_d = timeout_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      timeout_q <= timeout_d;
    end
endmodule

// File: doc/loop_seq_ctrl.md
LOOP_SEQ_CTRL -- requirements
Module: loop_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, register-file data width; ADDR_W, 2, register-file address width; REG_I, 1, index register; REG_SUM, 2, accumulator register; REG_STEP, 3, step register; MAX_ITER, 16, watchdog limit on accumulate passes.
REQ-002 Register 0 of the datapath reads as zero; REG_I, REG_SUM and REG_STEP SHALL be distinct, non-zero and < 2**ADDR_W.
REQ-003 Ports (name direction width meaning):
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-high.
  start  in  1  begin a run; sampled only in IDLE.
  abort  in  1  synchronous cancel of an active run.
  mode  in  1  step select: 0 = step 1, 1 = step 2; captured at start.
  iLe  in  1  datapath flag: R[REG_I] <= limit, valid while raddr1 = REG_I.
  rfsrcmuxsel  out  1  write source: 0 = ALU (raddr1 + raddr2), 1 = imm.
  imm  out  DATA_W  immediate write value.
  rfwe  out  1  register-file write enable.
  waddr, raddr1, raddr2  out  ADDR_W each  register-file addresses.
  outLoad  out  1  load output register from R[raddr1].
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle end-of-run pulse.
  timeout  out  1  last run ended by watchdog; held until next start or reset.

Function
REQ-004 States: IDLE, INIT_I, INIT_SUM, LOAD_STEP, ACC, INC, CHK, OUT, DONE.
REQ-005 IDLE: all outputs 0 (timeout holds); start=1 -> INIT_I, capture mode, clear iteration counter and timeout.
REQ-006 INIT_I: R[REG_I] = R0 + R0 (rfwe=1, rfsrcmuxsel=0, raddr1=raddr2=0, waddr=REG_I) -> INIT_SUM.
REQ-007 INIT_SUM: same with waddr=REG_SUM -> LOAD_STEP.
REQ-008 LOAD_STEP: rfsrcmuxsel=1, imm = 1 (mode 0) or 2 (mode 1) zero-extended, waddr=REG_STEP, rfwe=1 -> ACC.
REQ-009 ACC: raddr1=REG_SUM, raddr2=REG_I, waddr=REG_SUM, rfwe=1; iteration counter +1 -> INC.
REQ-010 INC: raddr1=REG_I, raddr2=REG_STEP, waddr=REG_I, rfwe=1 -> CHK.
REQ-011 CHK: raddr1=REG_I, rfwe=0; iLe=0 -> DONE; iLe=1 and counter = MAX_ITER -> DONE with timeout set; else -> OUT.
REQ-012 OUT: raddr1=REG_SUM, outLoad=1, rfwe=0 -> ACC.
REQ-013 DONE: raddr1=REG_SUM, outLoad=1, done=1 for exactly this cycle -> IDLE.
REQ-014 Outputs SHALL be combinational decodes of state (Moore); imm=0 outside LOAD_STEP; unlisted outputs 0.
REQ-015 start while busy SHALL be ignored; start in DONE SHALL NOT start a run (takes effect only from IDLE).
REQ-016 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, timeout unchanged; abort in IDLE ignored; abort beats start and iLe.
REQ-017 Iteration counter width clog2(MAX_ITER+1); SHALL never wrap (saturates at MAX_ITER).
REQ-018 Latency per loop pass: 4 cycles (ACC, INC, CHK, OUT); setup 3 cycles.

Reset
REQ-019 reset=1 SHALL force IDLE, counter 0, captured mode 0, timeout 0, all outputs 0, asynchronously, including mid-run; first run after release requires a fresh start.

Structure
REQ-020 Shared package holds state encoding (4-bit enum), rfsrcmuxsel constants (SRC_ALU, SRC_IMM) and the step immediates.
REQ-021 One sub-module, iter_watchdog: counter with clear, increment, and at_limit output; FSM lives in loop_seq_ctrl.

Verification (datapath model: 4x8 register file, R0=0, limit 10, iLe = R[raddr1] <= 10)
REQ-022 mode=0, start pulse -> done in 47th cycle after start sampled, final outLoad value 55, timeout=0, 10 intermediate OUT loads of 0,1,3,...,45.
REQ-023 mode=1, start -> final value 30 (0+2+...+10), timeout=0.
REQ-024 MAX_ITER=16, iLe forced 1 -> exactly 16 ACC cycles, done pulse, timeout=1; next start clears timeout.
REQ-025 abort asserted in 3rd ACC -> IDLE next cycle, done never pulses, busy=0; subsequent start yields 55.
REQ-026 reset asserted mid-INC -> all outputs 0 immediately; start held during busy and during DONE -> no second run.
